// File: rtl/adc_frame_reader.sv
// adc_frame_reader
//   Gates the power-up delay (dly_en / delay_done), then reads back-to-back serial
//   frames from the ADC over adc_cs_n / adc_sclk / adc_sdo, MSB first. Each frame
//   yields one sample, published as a single-cycle sample_valid pulse.
//
//   Ports
//     clk, rst_l      system clock, asynchronous active-low reset
//     start           level; conversions run continuously while high
//     dly_en          enable to the power-up delay timer
//     delay_done      power-up delay elapsed
//     adc_cs_n        ADC chip select (active low)
//     adc_sclk        ADC serial clock (idles high)
//     adc_sdo         ADC serial data, launched by the ADC on the SCLK falling edge
//     sample_data     last sample, held until the next sample_valid
//     sample_valid    one-cycle pulse; sample_data updates in the same cycle
//     busy            high in every state except IDLE
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   IDLE     | nothing running, delay timer disabled
//   WAIT_DLY | delay timer enabled, waiting for delay_done
//   CS_SETUP | adc_cs_n low, adc_sclk high, SCLK_DIV cycles of setup
//   SHIFT    | FRAME_BITS SCLK periods (low phase, then high phase)
//   DONE     | adc_cs_n high, sample published (first gap cycle)
//   GAP      | remaining CS_GAP-1 cycles of adc_cs_n high time

module adc_frame_reader #(
   parameter int SCLK_DIV   = 4,
   parameter int FRAME_BITS = 16,
   parameter int DATA_BITS  = 12,
   parameter int CS_GAP     = 2
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 start,
   output logic                 dly_en,
   input  logic                 delay_done,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   input  logic                 adc_sdo,
   output logic [DATA_BITS-1:0] sample_data,
   output logic                 sample_valid,
   output logic                 busy
);

   localparam int DIV_W = (SCLK_DIV > 1)   ? $clog2(SCLK_DIV)   : 1;
   localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int GAP_W = (CS_GAP > 2)     ? $clog2(CS_GAP - 1) : 1;

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = (CS_GAP > 2) ? GAP_W'(CS_GAP - 2) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DLY,
      S_CS_SETUP,
      S_SHIFT,
      S_DONE,
      S_GAP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 div_tc;
   logic                 shift_en;
   logic                 bit_end;

   always_comb begin
      state_nxt = state;
      div_tc    = (div_cnt == '0);
      // rising SCLK edge is the end of a low phase; end of a high phase closes a bit
      shift_en  = (state == S_SHIFT) && div_tc && !adc_sclk;
      bit_end   = (state == S_SHIFT) && div_tc && adc_sclk;
      case (state)
         S_IDLE:     if (start) state_nxt = S_WAIT_DLY;
         S_WAIT_DLY: begin
            if (!start)          state_nxt = S_IDLE;
            else if (delay_done) state_nxt = S_CS_SETUP;
         end
         S_CS_SETUP: if (div_tc) state_nxt = S_SHIFT;
         S_SHIFT:    if (bit_end && (bit_cnt == '0)) state_nxt = S_DONE;
         S_DONE: begin
            if (CS_GAP == 1) state_nxt = start ? S_CS_SETUP : S_IDLE;
            else             state_nxt = S_GAP;
         end
         S_GAP:      if (gap_cnt == '0) state_nxt = start ? S_CS_SETUP : S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from state_nxt so each one lines up with the state it describes.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state        <= S_IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         gap_cnt      <= '0;
         shift_reg    <= '0;
         dly_en       <= 1'b0;
         busy         <= 1'b0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b1;
         sample_data  <= '0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         dly_en       <= (state_nxt != S_IDLE);
         busy         <= (state_nxt != S_IDLE);
         adc_cs_n     <= !((state_nxt == S_CS_SETUP) || (state_nxt == S_SHIFT));
         sample_valid <= (state_nxt == S_DONE);
         if (state_nxt == S_DONE) sample_data <= shift_reg;

         // phase timer reloads on every state change and at every terminal count
         if ((state_nxt != state) || div_tc) div_cnt <= DIV_LOAD;
         else                                div_cnt <= div_cnt - DIV_W'(1);

         if (state_nxt == S_SHIFT) begin
            if (state != S_SHIFT) adc_sclk <= 1'b0;
            else if (div_tc)      adc_sclk <= ~adc_sclk;
         end else begin
            adc_sclk <= 1'b1;
         end

         if (state == S_CS_SETUP) bit_cnt <= BIT_LOAD;
         else if (bit_end)        bit_cnt <= bit_cnt - BIT_W'(1);

         // only the last DATA_BITS bits survive; leading frame bits fall off the top
         if (shift_en) shift_reg <= {shift_reg[DATA_BITS-2:0], adc_sdo};

         if (state != S_GAP)      gap_cnt <= GAP_LOAD;
         else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

endmodule
